vco_bank: RTL and testbench
===========================

VCO_BANK -- requirements
Module: vco_bank

Interface
REQ-001 Parameter DATA_W, default 8, output sample width per channel.
REQ-002 Parameter ACC_W, default 16, phase-accumulator width; SHALL satisfy ACC_W >= DATA_W+1.
REQ-003 Parameter N_CH, default 2, channel count (>=1); CH_W = max(1, clog2(N_CH)).
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_enable  in  1  accumulators advance when high.
REQ-007 i_sync  in  1  zero all accumulators.
REQ-008 i_cfg_valid  in  1  config request.
REQ-009 o_cfg_ready  out  1  config accept.
REQ-010 i_cfg_ch  in  CH_W  target channel.
REQ-011 i_cfg_freq  in  ACC_W  frequency word.
REQ-012 i_cfg_mode  in  2  0 saw, 1 square, 2 triangle, 3 mute.
REQ-013 i_cfg_rephase  in  1  zero target accumulator on apply.
REQ-014 o_cfg_err  out  1  one-cycle pulse, bad channel.
REQ-015 o_data  out  N_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
REQ-016 o_wrap  out  N_CH  one-cycle pulse per channel accumulator carry-out.

Function
REQ-017 acc[c] SHALL update to (acc[c]+freq[c]) mod 2^ACC_W each cycle i_enable=1; hold otherwise.
REQ-018 o_wrap[c] SHALL be registered carry-out of that addition, asserted the cycle acc[c] shows the wrapped value; 0 when i_enable=0.
REQ-019 o_data SHALL be a registered function of acc/mode: one-cycle latency after acc change.
REQ-020 Saw: acc[ACC_W-1 -: DATA_W]. Square: all DATA_W bits = acc[ACC_W-1]. Triangle: t=acc[ACC_W-2 -: DATA_W]; output t if acc MSB=0, else ~t. Mute: 0.
REQ-021 Config FSM states IDLE (ready=1), APPLY (ready=0); accept = valid && ready in IDLE -> APPLY; APPLY -> IDLE unconditionally next cycle.
REQ-022 In APPLY, captured freq/mode SHALL write to the target channel; acc[c]=0 that cycle if rephase captured, else normal update with old freq.
REQ-023 Captured i_cfg_ch >= N_CH: no state change; o_cfg_err pulses in the APPLY cycle.
REQ-024 i_sync=1 SHALL zero every acc next cycle, override i_enable and rephase; no o_wrap that cycle; freq/mode writes in the same cycle still take effect.
REQ-025 Minimum config throughput: one accept per 2 cycles; valid held high is accepted again in the cycle after APPLY.

Reset
REQ-026 While i_reset=1: acc, freq = 0; mode = 0 (saw); o_data, o_wrap, o_cfg_err, o_cfg_ready = 0; FSM = IDLE.
REQ-027 o_cfg_ready SHALL first assert the cycle after i_reset deasserts; reset mid-APPLY discards the pending write.

Structure
REQ-028 Shared package holds mode encodings (MODE_SAW/SQR/TRI/MUTE), FSM state enum, and the ACC_W >= DATA_W+1 check constant.
REQ-029 One sub-module vco_chan (accumulator, carry, waveform shaper, output register) SHALL be instantiated N_CH times; config FSM in top level.

Verification (DATA_W=8, ACC_W=16, N_CH=3)
REQ-030 Reset, cfg ch0 freq=0x0100 saw, enable -> ch0 o_data 0x00,0x01,0x02... one per cycle; o_wrap[0] every 256 cycles.
REQ-031 ch1 freq=0x8000 square -> o_data ch1 alternates 0x00/0xFF; o_wrap[1] every second cycle.
REQ-032 ch2 freq=0x0100 triangle -> 0x00,0x02,...,0xFE then 0xFF,0xFD,...,0x01, repeat.
REQ-033 i_cfg_valid held 3 cycles -> ready pattern 1,0,1; two writes land; i_cfg_ch=3 -> o_cfg_err one pulse, all channels unchanged.
REQ-034 freq=0xFFFF -> acc decrements by 1, o_wrap high every cycle except acc 0x0000->0xFFFF.
REQ-035 i_sync mid-run with concurrent cfg, then i_reset mid-APPLY -> accumulators 0, freq from sync-cycle write kept; after reset all outputs 0, pending write lost.

Source files
------------

// File: rtl/vco_bank_pkg.sv
// ============================================================================
// vco_bank_pkg : shared types and constants for the VCO bank.
// Rev 1.0
// ============================================================================
`default_nettype none

package vco_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SAW  = 2'd0,
    MODE_SQR  = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_MUTE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } cfg_state_e;

  // Triangle needs one accumulator bit above the DATA_W bits it folds.
  localparam int ACC_GUARD_BITS = 1;

  function automatic bit acc_w_ok(input int acc_w, input int data_w);
    return acc_w >= data_w + ACC_GUARD_BITS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vco_bank_if.sv
// ============================================================================
// vco_bank_if : configuration request/accept handshake of the VCO bank.
// Rev 1.0
// ============================================================================
`default_nettype none

interface vco_bank_if #(
  parameter int ACC_W = 16,
  parameter int N_CH  = 2
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [CH_W-1:0]  i_cfg_ch;
  logic [ACC_W-1:0] i_cfg_freq;
  logic [1:0]       i_cfg_mode;
  logic             i_cfg_rephase;
  logic             o_cfg_err;

  modport master (
    output i_cfg_valid, i_cfg_ch, i_cfg_freq, i_cfg_mode, i_cfg_rephase,
    input  o_cfg_ready, o_cfg_err
  );

  modport slave (
    input  i_cfg_valid, i_cfg_ch, i_cfg_freq, i_cfg_mode, i_cfg_rephase,
    output o_cfg_ready, o_cfg_err
  );

endinterface

`default_nettype wire

// File: rtl/vco_chan.sv
// ============================================================================
// vco_chan : one oscillator channel - phase accumulator, carry, shaper, output.
// Rev 1.0
// ============================================================================
`default_nettype none

module vco_chan
  import vco_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_sync,
  input  logic              i_wr,
  input  logic [ACC_W-1:0]  i_wr_freq,
  input  mode_e             i_wr_mode,
  input  logic              i_wr_rephase,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wrap
);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  freq_q, freq_d;
  mode_e             mode_q, mode_d;
  logic              wrap_q, wrap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ACC_W:0]    sum;
  logic [DATA_W-1:0] tri_val;

  // The accumulator always advances with the frequency held before this cycle's write.
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, freq_q};
    acc_d  = acc_q;
    freq_d = freq_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (i_wr) begin
      freq_d = i_wr_freq;
      mode_d = i_wr_mode;
    end
    if (i_sync) begin
      acc_d = '0;
    end else if (i_wr && i_wr_rephase) begin
      acc_d = '0;
    end else if (i_enable) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = sum[ACC_W];
    end
  end

  always_comb begin
    tri_val = acc_q[ACC_W-2 -: DATA_W];
    case (mode_q)
      MODE_SAW: data_d = acc_q[ACC_W-1 -: DATA_W];
      MODE_SQR: data_d = {DATA_W{acc_q[ACC_W-1]}};
      MODE_TRI: data_d = acc_q[ACC_W-1] ? ~tri_val : tri_val;
      default:  data_d = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q  <= '0;
      freq_q <= '0;
      mode_q <= MODE_SAW;
      wrap_q <= 1'b0;
      data_q <= '0;
    end else begin
      acc_q  <= acc_d;
      freq_q <= freq_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      data_q <= data_d;
    end
  end

  assign o_data = data_q;
  assign o_wrap = wrap_q;

endmodule

`default_nettype wire

// File: rtl/vco_bank.sv
// ============================================================================
// vco_bank : N_CH phase-accumulator oscillators with a two-state config port.
// Rev 1.0
// ============================================================================
`default_nettype none

module vco_bank
  import vco_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int N_CH   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_sync,
  vco_bank_if.slave              cfg,
  output logic [N_CH*DATA_W-1:0] o_data,
  output logic [N_CH-1:0]        o_wrap
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W:0] C_N_CH = (CH_W + 1)'(N_CH);

  if (!acc_w_ok(ACC_W, DATA_W)) begin : g_acc_w_check
    $error("vco_bank: ACC_W must be at least DATA_W+1");
  end

  cfg_state_e       state_q;
  logic             ready_q;
  logic             err_q;
  logic [CH_W-1:0]  cfg_ch_q;
  logic [ACC_W-1:0] cfg_freq_q;
  mode_e            cfg_mode_q;
  logic             cfg_rephase_q;
  logic             bad_ch;

  assign bad_ch = ({1'b0, cfg.i_cfg_ch} >= C_N_CH);

  // Request is captured on accept and written to its channel during APPLY.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
      cfg_ch_q      <= '0;
      cfg_freq_q    <= '0;
      cfg_mode_q    <= MODE_SAW;
      cfg_rephase_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg.i_cfg_valid && ready_q) begin
            state_q       <= ST_APPLY;
            ready_q       <= 1'b0;
            err_q         <= bad_ch;
            cfg_ch_q      <= cfg.i_cfg_ch;
            cfg_freq_q    <= cfg.i_cfg_freq;
            cfg_mode_q    <= mode_e'(cfg.i_cfg_mode);
            cfg_rephase_q <= cfg.i_cfg_rephase;
          end else begin
            ready_q <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.o_cfg_ready = ready_q;
  assign cfg.o_cfg_err   = err_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    logic wr;
    assign wr = (state_q == ST_APPLY) && (cfg_ch_q == CH_W'(c));

    vco_chan #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_chan (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_sync       (i_sync),
      .i_wr         (wr),
      .i_wr_freq    (cfg_freq_q),
      .i_wr_mode    (cfg_mode_q),
      .i_wr_rephase (cfg_rephase_q),
      .o_data       (o_data[c*DATA_W +: DATA_W]),
      .o_wrap       (o_wrap[c])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_vco_bank.sv
// ============================================================================
// tb_vco_bank : directed stimulus with a cycle model and literal spot checks.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vco_bank;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int NC = 3;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          en   = 1'b0;
  logic          sync = 1'b0;
  logic [NC*DW-1:0] data;
  logic [NC-1:0]    wrap;

  int n_pass  = 0;
  int n_total = 0;

  vco_bank_if #(.ACC_W(AW), .N_CH(NC)) cfg_if ();

  vco_bank #(.DATA_W(DW), .ACC_W(AW), .N_CH(NC)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_enable (en),
    .i_sync   (sync),
    .cfg      (cfg_if),
    .o_data   (data),
    .o_wrap   (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int  m_acc[NC];
  int  m_freq[NC];
  int  m_mode[NC];
  bit  m_ready = 0, m_pend = 0, m_err = 0, m_preph = 0;
  int  m_pch = 0, m_pfreq = 0, m_pmode = 0;
  logic [NC*DW-1:0] e_data = '0;
  logic [NC-1:0]    e_wrap = '0;
  bit  started = 0;

  function automatic int shape(input int acc, input int mode);
    int t;
    case (mode)
      0: return acc / 256;
      1: return (acc >= 32768) ? 255 : 0;
      2: begin
        t = (acc / 128) % 256;
        return (acc >= 32768) ? 255 - t : t;
      end
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int  s, old_f;
    bit  hit, accept;
    started = 1;
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        m_acc[c] = 0; m_freq[c] = 0; m_mode[c] = 0;
      end
      e_data = '0; e_wrap = '0;
      m_ready = 0; m_pend = 0; m_err = 0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        e_data[c*DW +: DW] = DW'(shape(m_acc[c], m_mode[c]));
        hit   = m_pend && (m_pch == c);
        old_f = m_freq[c];
        if (hit) begin
          m_freq[c] = m_pfreq;
          m_mode[c] = m_pmode;
        end
        e_wrap[c] = 1'b0;
        if (sync) m_acc[c] = 0;
        else if (hit && m_preph) m_acc[c] = 0;
        else if (en) begin
          s = m_acc[c] + old_f;
          e_wrap[c] = (s > 65535);
          m_acc[c]  = s % 65536;
        end
      end
      accept = cfg_if.i_cfg_valid && m_ready;
      m_err  = accept && (int'(cfg_if.i_cfg_ch) >= NC);
      if (accept) begin
        m_pch   = int'(cfg_if.i_cfg_ch);
        m_pfreq = int'(cfg_if.i_cfg_freq);
        m_pmode = int'(cfg_if.i_cfg_mode);
        m_preph = cfg_if.i_cfg_rephase;
      end
      m_pend  = accept;
      m_ready = !accept;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_data",  32'(data), 32'(e_data));
      chk("model_wrap",  32'(wrap), 32'(e_wrap));
      chk("model_ready", 32'(cfg_if.o_cfg_ready), 32'(m_ready));
      chk("model_err",   32'(cfg_if.o_cfg_err), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_cfg(input int ch, input int freq, input int mode, input bit reph);
    bit done;
    done = 0;
    cfg_if.i_cfg_ch      = 2'(ch);
    cfg_if.i_cfg_freq    = 16'(freq);
    cfg_if.i_cfg_mode    = 2'(mode);
    cfg_if.i_cfg_rephase = reph;
    cfg_if.i_cfg_valid   = 1'b1;
    for (int k = 0; k < 10 && !done; k++) begin
      if (cfg_if.o_cfg_ready) done = 1;
      @(negedge clk);
    end
    cfg_if.i_cfg_valid = 1'b0;
    chk("cfg_accepted", 32'(done), 32'd1);
  endtask

  initial begin
    int wr0, wr1;
    logic [2:0] pat;
    cfg_if.i_cfg_valid   = 1'b0;
    cfg_if.i_cfg_ch      = '0;
    cfg_if.i_cfg_freq    = '0;
    cfg_if.i_cfg_mode    = '0;
    cfg_if.i_cfg_rephase = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_data",  32'(data), 32'd0);
    chk("rst_wrap",  32'(wrap), 32'd0);
    chk("rst_ready", 32'(cfg_if.o_cfg_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cfg_if.o_cfg_ready), 32'd1);

    do_cfg(0, 16'h0100, 0, 0);
    do_cfg(1, 16'h8000, 1, 0);
    do_cfg(2, 16'h0100, 2, 0);
    @(negedge clk);
    en = 1'b1;
    wr0 = 0; wr1 = 0;
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      wr0 += int'(wrap[0]);
      wr1 += int'(wrap[1]);
      if (k <= 4) begin
        chk("saw_ch0", 32'(data[7:0]),   32'(k - 1));
        chk("sqr_ch1", 32'(data[15:8]),  (k % 2 == 0) ? 32'hFF : 32'h00);
        chk("tri_ch2", 32'(data[23:16]), 32'(2 * (k - 1)));
      end
      if (k == 128) chk("tri_peak_lo", 32'(data[23:16]), 32'hFE);
      if (k == 129) chk("tri_peak",    32'(data[23:16]), 32'hFF);
      if (k == 130) chk("tri_fall",    32'(data[23:16]), 32'hFD);
    end
    chk("wrap0_count", 32'(wr0), 32'd2);
    chk("wrap1_count", 32'(wr1), 32'd256);

    // valid held for three cycles: two back-to-back writes
    cfg_if.i_cfg_ch = 2'd0; cfg_if.i_cfg_freq = 16'h0200;
    cfg_if.i_cfg_mode = 2'd0; cfg_if.i_cfg_rephase = 1'b0;
    cfg_if.i_cfg_valid = 1'b1;
    pat[0] = cfg_if.o_cfg_ready;
    @(negedge clk);
    pat[1] = cfg_if.o_cfg_ready;
    cfg_if.i_cfg_ch = 2'd1; cfg_if.i_cfg_freq = 16'h4000; cfg_if.i_cfg_rephase = 1'b1;
    @(negedge clk);
    pat[2] = cfg_if.o_cfg_ready;
    @(negedge clk);
    cfg_if.i_cfg_valid = 1'b0;
    chk("ready_pattern", 32'(pat), 32'b101);
    @(negedge clk);

    do_cfg(3, 16'h1111, 3, 1);
    chk("err_pulse", 32'(cfg_if.o_cfg_err), 32'd1);
    @(negedge clk);
    chk("err_cleared", 32'(cfg_if.o_cfg_err), 32'd0);

    do_cfg(2, 16'hFFFF, 0, 1);
    @(negedge clk);
    chk("dec_a_wrap", 32'(wrap[2]), 32'd0);
    @(negedge clk);
    chk("dec_b_wrap", 32'(wrap[2]), 32'd0);
    chk("dec_b_data", 32'(data[23:16]), 32'h00);
    @(negedge clk);
    chk("dec_c_wrap", 32'(wrap[2]), 32'd1);
    chk("dec_c_data", 32'(data[23:16]), 32'hFF);
    @(negedge clk);
    chk("dec_d_wrap", 32'(wrap[2]), 32'd1);

    do_cfg(0, 16'h0300, 2, 0);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    chk("sync_data0", 32'(data[7:0]), 32'd0);
    @(negedge clk);
    chk("sync_freq_kept", 32'(data[7:0]), 32'd6);

    do_cfg(1, 16'h1234, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_data",  32'(data), 32'd0);
    chk("midrst_wrap",  32'(wrap), 32'd0);
    chk("midrst_ready", 32'(cfg_if.o_cfg_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_back", 32'(cfg_if.o_cfg_ready), 32'd1);
    repeat (5) @(negedge clk);
    chk("post_rst_data", 32'(data), 32'd0);
    chk("post_rst_wrap", 32'(wrap), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
